alu_issue: RTL and testbench

Multi-cycle issue/sequencing controller that drives the rv32i ALU's control and operand inputs and consumes its result and zero flag. It accepts one instruction word per valid/ready handshake, decodes the supported subset (ADD/SUB/AND/OR, ADDI/ANDI/ORI, BEQ/BNE), reads operands from the register file, sequences one ALU operation, and emits a one-cycle writeback, branch-resolve or illegal pulse. It sits between instruction fetch and the register file and ALU in the partial rv32i core.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_op_decode.sv | 65 ++++++
 rtl/alu_issue.sv | 126 ++++++++++++
 tb/tb_alu_issue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and encodings for the ALU issue controller
package alu_pkg;

   // ALU control encoding (also used by the rv32i ALU itself)
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110
   } alu_op_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [1:0] {
      CLS_RTYPE,
      CLS_ITYPE,
      CLS_BRANCH,
      CLS_ILLEGAL
   } instr_class_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_DONE
   } state_t;

   // I-type immediate: sign-extend the 12-bit field to XLEN
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational decode of the supported rv32i subset
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0]  instr,
   output alu_op_t      alu_op,
   output instr_class_t cls,
   output logic [4:0]   rd,
   output logic [4:0]   rs1,
   output logic [4:0]   rs2,
   output logic [31:0]  imm,
   output logic         illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign rd     = instr[11:7];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign imm    = sext12(instr[31:20]);

   // map opcode/funct fields to an ALU operation and instruction class
   always_comb begin
      alu_op = ALU_AND;
      cls    = CLS_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  begin alu_op = ALU_ADD; cls = CLS_RTYPE; end
                  F3_AND:  begin alu_op = ALU_AND; cls = CLS_RTYPE; end
                  F3_OR:   begin alu_op = ALU_OR;  cls = CLS_RTYPE; end
                  default: ;
               endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
               alu_op = ALU_SUB;
               cls    = CLS_RTYPE;
            end
         end
         OP_ITYPE: begin
            case (funct3)
               F3_ADD:  begin alu_op = ALU_ADD; cls = CLS_ITYPE; end
               F3_AND:  begin alu_op = ALU_AND; cls = CLS_ITYPE; end
               F3_OR:   begin alu_op = ALU_OR;  cls = CLS_ITYPE; end
               default: ;
            endcase
         end
         OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               alu_op = ALU_SUB;
               cls    = CLS_BRANCH;
            end
         end
         default: ;
      endcase
   end

   assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - four-state issue/sequencing controller for the rv32i ALU
module alu_issue
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_in_a,
   output logic [31:0] alu_in_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        wb_valid,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        br_valid,
   output logic        br_taken,
   output logic        illegal
);

   state_t       state, state_nx;
   logic [31:0]  instr_q;
   instr_class_t cls_q;
   logic [4:0]   rd_q;
   logic         bne_q;

   alu_op_t      dec_op;
   instr_class_t dec_cls;
   logic [4:0]   dec_rd, dec_rs1, dec_rs2;
   logic [31:0]  dec_imm;
   logic         dec_illegal;

   alu_op_decode u_decode (
      .instr   (instr_q),
      .alu_op  (dec_op),
      .cls     (dec_cls),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next-state: fixed IDLE -> DECODE -> EXEC -> DONE walk once a word is taken
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (instr_valid) state_nx = ST_DECODE;
         ST_DECODE: state_nx = ST_EXEC;
         ST_EXEC:   state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign instr_ready = (state == ST_IDLE) && !rst;
   assign rs1_addr    = (state == ST_DECODE && !rst) ? dec_rs1 : 5'd0;
   assign rs2_addr    = (state == ST_DECODE && !rst) ? dec_rs2 : 5'd0;

   // datapath: latch word, load ALU operands in DECODE, capture result/strobes in EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q  <= 32'd0;
         cls_q    <= CLS_ILLEGAL;
         rd_q     <= 5'd0;
         bne_q    <= 1'b0;
         alu_op   <= 4'd0;
         alu_in_a <= 32'd0;
         alu_in_b <= 32'd0;
         wb_valid <= 1'b0;
         wb_addr  <= 5'd0;
         wb_data  <= 32'd0;
         br_valid <= 1'b0;
         br_taken <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         br_valid <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (instr_valid) instr_q <= instr;
            end
            ST_DECODE: begin
               cls_q    <= dec_illegal ? CLS_ILLEGAL : dec_cls;
               rd_q     <= dec_rd;
               bne_q    <= (instr_q[14:12] == F3_BNE);
               alu_op   <= dec_op;
               alu_in_a <= rs1_data;
               alu_in_b <= (dec_cls == CLS_ITYPE) ? dec_imm : rs2_data;
            end
            ST_EXEC: begin
               case (cls_q)
                  CLS_RTYPE, CLS_ITYPE: begin
                     // writes to x0 are dropped silently
                     if (rd_q != 5'd0) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_q;
                        wb_data  <= alu_result;
                     end
                  end
                  CLS_BRANCH: begin
                     br_valid <= 1'b1;
                     br_taken <= bne_q ? !alu_zero : alu_zero;
                  end
                  default: illegal <= 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized and directed self-checking bench for alu_issue
module tb_alu_issue;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_in_a, alu_in_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        br_valid, br_taken, illegal;

   logic [31:0] regs [32];
   int          checks = 0;
   int          passed = 0;

   alu_issue dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .alu_op      (alu_op),
      .alu_in_a    (alu_in_a),
      .alu_in_b    (alu_in_b),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .br_valid    (br_valid),
      .br_taken    (br_taken),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];

   // environment ALU
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      case (alu_op)
         4'b0000: alu_result = alu_in_a & alu_in_b;
         4'b0001: alu_result = alu_in_a | alu_in_b;
         4'b0010: alu_result = alu_in_a + alu_in_b;
         4'b0110: alu_result = alu_in_a - alu_in_b;
         default: ;
      endcase
   end
   assign alu_zero = (alu_result == 32'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {7'd0, rs2, rs1, f3, 5'd0, 7'h63};
   endfunction

   // reference: kind 0 = no strobe, 1 = writeback, 2 = branch, 3 = illegal
   function automatic void model(input logic [31:0] ins, output int kind,
                                 output logic [4:0] eaddr, output logic [31:0] edata,
                                 output logic etaken, output logic [3:0] eop,
                                 output logic [31:0] ea, output logic [31:0] eb);
      logic [31:0] a, b, imm;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      a   = regs[ins[19:15]];
      b   = regs[ins[24:20]];
      imm = {{20{ins[31]}}, ins[31:20]};
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      kind = 3; eaddr = ins[11:7]; edata = 32'd0; etaken = 1'b0; eop = 4'd0;
      ea = a; eb = b;
      if (opc == 7'h33) begin
         if (f7 == 7'h00 && f3 == 3'd0)      begin kind = 1; edata = a + b; eop = 4'd2; end
         else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 1; edata = a - b; eop = 4'd6; end
         else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 1; edata = a & b; eop = 4'd0; end
         else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 1; edata = a | b; eop = 4'd1; end
      end else if (opc == 7'h13) begin
         eb = imm;
         if (f3 == 3'd0)      begin kind = 1; edata = a + imm; eop = 4'd2; end
         else if (f3 == 3'd7) begin kind = 1; edata = a & imm; eop = 4'd0; end
         else if (f3 == 3'd6) begin kind = 1; edata = a | imm; eop = 4'd1; end
      end else if (opc == 7'h63) begin
         if (f3 == 3'd0)      begin kind = 2; eop = 4'd6; etaken = (a == b); end
         else if (f3 == 3'd1) begin kind = 2; eop = 4'd6; etaken = (a != b); end
      end
      if (kind == 1 && eaddr == 5'd0) kind = 0;
   endfunction

   function automatic logic [31:0] gen();
      logic [31:0] r;
      logic [2:0]  f3tab [4];
      int          k;
      f3tab = '{3'b000, 3'b111, 3'b110, 3'b000};
      r = $urandom;
      k = $urandom_range(0, 7);
      case (k)
         0, 1: begin
            r[6:0] = 7'h33; r[14:12] = f3tab[r[1:0] + 2'd1];
            r[31:25] = (r[12] && r[14:12] == 3'd0) ? 7'h20 : 7'h00;
         end
         2: begin r[6:0] = 7'h33; r[31:25] = r[25] ? 7'h20 : 7'h00; end
         3: begin r[6:0] = 7'h13; r[14:12] = f3tab[r[26:25]]; end
         4: r[6:0] = 7'h13;
         5: begin r[6:0] = 7'h63; r[14:13] = 2'b00; end
         6: r[6:0] = 7'h63;
         default: ;
      endcase
      return r;
   endfunction

   // one full instruction with stage-by-stage checks
   task automatic issue(input logic [31:0] ins);
      int          kind, w;
      logic [4:0]  ea5;
      logic [31:0] ed, ea, eb;
      logic        et;
      logic [3:0]  eop;
      model(ins, kind, ea5, ed, et, eop, ea, eb);
      w = 0;
      while (!instr_ready && w < 20) begin @(posedge clk); #1; w++; end
      chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instr       = ins;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = $urandom;
      chk("decode_rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
      chk("decode_rs2_addr", {27'd0, rs2_addr}, {27'd0, ins[24:20]});
      chk("decode_ready_low", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      if (kind != 3) begin
         chk("exec_alu_op", {28'd0, alu_op}, {28'd0, eop});
         chk("exec_alu_in_a", alu_in_a, ea);
         chk("exec_alu_in_b", alu_in_b, eb);
      end
      chk("exec_no_strobe", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
      @(posedge clk); #1;
      chk("done_wb_valid", {31'd0, wb_valid}, {31'd0, kind == 1});
      chk("done_br_valid", {31'd0, br_valid}, {31'd0, kind == 2});
      chk("done_illegal", {31'd0, illegal}, {31'd0, kind == 3});
      if (kind == 1) begin
         chk("done_wb_addr", {27'd0, wb_addr}, {27'd0, ea5});
         chk("done_wb_data", wb_data, ed);
      end
      if (kind == 2) chk("done_br_taken", {31'd0, br_taken}, {31'd0, et});
      @(posedge clk); #1;
      chk("idle_strobes_clear", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
      chk("idle_ready", {31'd0, instr_ready}, 32'd1);
   endtask

   logic [31:0] bb [3];
   int          hs [3];
   int          st [3];
   int          nh, ns, kind_b;
   logic        took, et_b;
   logic [4:0]  ea_b;
   logic [31:0] ed_b, ea32_b, eb32_b;
   logic [3:0]  eop_b;
   int          quiet;

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {31'd0, instr_ready}, 32'd0);
      chk("reset_strobes", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
      chk("reset_alu_op", {28'd0, alu_op}, 32'd0);
      chk("reset_alu_in_a", alu_in_a, 32'd0);
      chk("reset_alu_in_b", alu_in_b, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

      // directed cases
      regs[1] = 32'h0000_0005; regs[2] = 32'h0000_0007;
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
      chk("add_result", wb_data, 32'h0000_000C);
      regs[1] = 32'h0;
      issue(enc_i(12'hFFF, 5'd1, 3'd0, 5'd4));
      chk("addi_result", wb_data, 32'hFFFF_FFFF);
      issue(enc_i(12'h0F0, 5'd0, 3'd6, 5'd5));
      chk("ori_result", wb_data, 32'h0000_00F0);
      regs[1] = 32'h1234; regs[2] = 32'h1234;
      issue(enc_b(5'd2, 5'd1, 3'd0));
      issue(enc_b(5'd2, 5'd1, 3'd1));
      issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd0));
      issue({25'h0AB_CDEF, 7'b0000011});

      // back-to-back with instr_valid held high
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      bb[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6);
      bb[1] = enc_r(7'h20, 5'd4, 5'd3, 3'd0, 5'd7);
      bb[2] = enc_i(12'h5A5, 5'd9, 3'd6, 5'd8);
      nh = 0; ns = 0;
      instr_valid = 1'b1;
      instr       = bb[0];
      for (int c = 0; c < 16; c++) begin
         took = instr_valid && instr_ready;
         if (took && nh < 3) begin hs[nh] = c; nh++; end
         if (wb_valid && ns < 3) begin
            model(bb[ns], kind_b, ea_b, ed_b, et_b, eop_b, ea32_b, eb32_b);
            chk("b2b_wb_addr", {27'd0, wb_addr}, {27'd0, ea_b});
            chk("b2b_wb_data", wb_data, ed_b);
            st[ns] = c; ns++;
         end
         @(posedge clk); #1;
         if (took) begin
            if (nh < 3) instr = bb[nh];
            else instr_valid = 1'b0;
         end
      end
      instr_valid = 1'b0;
      chk("b2b_handshakes", nh, 3);
      chk("b2b_strobes", ns, 3);
      if (nh == 3 && ns == 3) begin
         chk("b2b_gap_1", hs[1] - hs[0], 4);
         chk("b2b_gap_2", hs[2] - hs[1], 4);
         for (int i = 0; i < 3; i++) chk("b2b_strobe_latency", st[i] - hs[i], 3);
      end

      // reset while in EXEC
      instr_valid = 1'b1;
      instr       = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_mid_strobes", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
      chk("rst_mid_alu_op", {28'd0, alu_op}, 32'd0);
      chk("rst_mid_alu_in_a", alu_in_a, 32'd0);
      chk("rst_mid_alu_in_b", alu_in_b, 32'd0);
      chk("rst_mid_wb", {wb_addr, wb_data[26:0]}, 32'd0);
      chk("rst_mid_rs_addr", {22'd0, rs1_addr, rs2_addr}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready_after", {31'd0, instr_ready}, 32'd1);
      quiet = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (wb_valid || br_valid || illegal) quiet++;
      end
      chk("rst_mid_no_strobe", quiet, 0);
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd10));

      // randomized instructions, some registers small so branches hit both ways
      for (int i = 1; i < 32; i++) regs[i] = (i < 16) ? $urandom : $urandom_range(0, 3);
      for (int n = 0; n < 40; n++) issue(gen());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
